// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and default sizing for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam int DEF_NUM_DOMAINS = 4;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_GAP_CYCLES  = 8;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/rst_sync.sv
// rtl/rst_sync.sv - async-assert, sync-deassert reset synchronizer
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - releases NUM_DOMAINS resets in order after a synchronized board reset
// Define RST_SEQ_CHECK_EN to compile the embedded protocol assertions.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_out_n,
    output logic                   seq_done,
    output logic                   busy
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    logic                   rst_sync_w;
    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic [NUM_DOMAINS-1:0] rst_out_n_q;
    logic                   seq_done_q;
    logic                   busy_q;

    rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_sync(rst_sync_w)
    );

    // Everything stays frozen in HOLD until the synchronized reset has deasserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_out_n_q <= '0;
            seq_done_q  <= 1'b0;
            busy_q      <= 1'b1;
        end else if (rst_sync_w) begin
            if (sw_rst_req) begin
                state_q     <= HOLD;
                cnt_q       <= '0;
                idx_q       <= '0;
                rst_out_n_q <= '0;
                seq_done_q  <= 1'b0;
                busy_q      <= 1'b1;
            end else begin
                case (state_q)
                    HOLD: begin
                        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                            state_q <= RELEASE;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                            rst_out_n_q[idx_q] <= 1'b1;
                            cnt_q              <= '0;
                            if (idx_q == IW'(NUM_DOMAINS - 1)) begin
                                state_q    <= DONE;
                                seq_done_q <= 1'b1;
                                busy_q     <= 1'b0;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: begin
                        state_q <= HOLD;
                    end
                endcase
            end
        end
    end

    assign rst_out_n = rst_out_n_q;
    assign seq_done  = seq_done_q;
    assign busy      = busy_q;

`ifdef RST_SEQ_CHECK_EN
    logic [NUM_DOMAINS:0] therm_ext;
    assign therm_ext = {1'b0, rst_out_n_q};

    a_thermometer: assert property (@(posedge clk) disable iff (!rst_n)
        (therm_ext & (therm_ext + 1'b1)) == '0)
        else $error("reset_sequencer: rst_out_n not thermometer at %0t", $time);

    a_done_stable: assert property (@(posedge clk) disable iff (!rst_n)
        seq_done_q |-> (&rst_out_n_q))
        else $error("reset_sequencer: output dropped while done at %0t", $time);

    a_sw_clear: assert property (@(posedge clk) disable iff (!rst_n)
        (sw_rst_req && rst_sync_w) |=> (rst_out_n_q == '0))
        else $error("reset_sequencer: sw request did not clear outputs at %0t", $time);

    for (genvar k = 1; k < NUM_DOMAINS; k++) begin : g_gap_chk
        a_gap: assert property (@(posedge clk) disable iff (!rst_n)
            $rose(rst_out_n_q[k]) |->
                ($past(rst_out_n_q[k-1], GAP_CYCLES) && !$past(rst_out_n_q[k-1], GAP_CYCLES + 1)))
            else $error("reset_sequencer: domain %0d released off-gap at %0t", k, $time);
    end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed bench with an edge-count model of the release schedule
module tb_reset_sequencer;

    localparam int SYNC = 2;
    localparam int H0 = 16, G0 = 8, N0 = 4;
    localparam int H1 = 1,  G1 = 1, N1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sw_rst_req;
    logic [3:0] r0;
    logic       d0, b0;
    logic [0:0] r1;
    logic       d1, b1;

    reset_sequencer #(
        .NUM_DOMAINS(N0), .HOLD_CYCLES(H0), .GAP_CYCLES(G0), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
        .rst_out_n(r0), .seq_done(d0), .busy(b0)
    );

    reset_sequencer #(
        .NUM_DOMAINS(N1), .HOLD_CYCLES(H1), .GAP_CYCLES(G1), .SYNC_STAGES(SYNC)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
        .rst_out_n(r1), .seq_done(d1), .busy(b1)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Number of domains released e edges after the first edge that sees the synchronized reset.
    function automatic int released(input int e, input int h, input int g, input int n);
        int m = 0;
        for (int k = 0; k < n; k++) if (e >= h + (k + 1) * g - 1) m++;
        return m;
    endfunction

    int nedge = 0;
    int e0 = -1;
    int e1 = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nedge = 0;
            e0 = -1;
            e1 = -1;
        end else begin
            if (nedge < 1000) nedge++;
            if (nedge >= SYNC + 1) begin
                if (sw_rst_req) begin
                    e0 = -1;
                    e1 = -1;
                end else begin
                    if (e0 < 100000) e0++;
                    if (e1 < 100000) e1++;
                end
            end
        end
    end

    always @(negedge clk) begin
        int m0, m1;
        m0 = released(e0, H0, G0, N0);
        m1 = released(e1, H1, G1, N1);
        check("model rst_out_n", {28'd0, r0}, (1 << m0) - 1);
        check("model seq_done", {31'd0, d0}, {31'd0, m0 == N0});
        check("model busy", {31'd0, b0}, {31'd0, m0 != N0});
        check("model1 rst_out_n", {31'd0, r1}, (1 << m1) - 1);
        check("model1 seq_done", {31'd0, d1}, {31'd0, m1 == N1});
        check("model1 busy", {31'd0, b1}, {31'd0, m1 != N1});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;
        tick(3);
        check("reset rst_out_n", {28'd0, r0}, 32'h0);
        check("reset seq_done", {31'd0, d0}, 32'h0);
        check("reset busy", {31'd0, b0}, 32'h1);
        check("reset1 busy", {31'd0, b1}, 32'h1);

        rst_n = 1'b1;
        tick(3);
        check("small pre-release", {31'd0, r1}, 32'h0);
        tick(1);
        check("small release", {31'd0, r1}, 32'h1);
        check("small done", {31'd0, d1}, 32'h1);
        tick(21);
        check("pon edge22", {28'd0, r0}, 32'h0);
        tick(1);
        check("pon edge23", {28'd0, r0}, 32'h1);
        tick(8);
        check("pon edge31", {28'd0, r0}, 32'h3);
        tick(8);
        check("pon edge39", {28'd0, r0}, 32'h7);
        tick(7);
        check("pon edge46 done", {31'd0, d0}, 32'h0);
        tick(1);
        check("pon edge47", {28'd0, r0}, 32'hF);
        check("pon edge47 done", {31'd0, d0}, 32'h1);
        check("pon edge47 busy", {31'd0, b0}, 32'h0);

        tick(5);
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        check("sw done clear", {28'd0, r0}, 32'h0);
        check("sw done seq_done", {31'd0, d0}, 32'h0);
        check("sw done busy", {31'd0, b0}, 32'h1);
        tick(23);
        check("sw rerun edge22", {28'd0, r0}, 32'h0);
        tick(1);
        check("sw rerun edge23", {28'd0, r0}, 32'h1);
        tick(24);
        check("sw rerun edge47", {28'd0, r0}, 32'hF);

        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        tick(32);
        check("mid at 0011", {28'd0, r0}, 32'h3);
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        check("mid clear", {28'd0, r0}, 32'h0);
        tick(23);
        check("mid +23", {28'd0, r0}, 32'h0);
        tick(1);
        check("mid +24", {28'd0, r0}, 32'h1);

        tick(3);
        rst_n = 1'b0;
        #1;
        check("async rst_out_n", {28'd0, r0}, 32'h0);
        check("async busy", {31'd0, b0}, 32'h1);
        check("async1 rst_out_n", {31'd0, r1}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(25);
        check("rerst edge22", {28'd0, r0}, 32'h0);
        tick(1);
        check("rerst edge23", {28'd0, r0}, 32'h1);
        tick(24);
        check("rerst edge47", {28'd0, r0}, 32'hF);
        tick(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
